mem_fill_arbiter: RTL and testbench
===================================

// Module: mem_fill_arbiter
// PURPOSE
//  Shares the single pipelined main-memory port between I-cache miss fills, D-cache miss fills and
//  D-cache write-through stores. Grants one requester at a time and sequences 8-word (16-byte)
//  block fills. Sits between both caches and main memory inside cpu; the pipeline stalls on cache busy.
// PARAMETERS
//  ADDR_W   16  byte-address width
//  DATA_W   16  word width
//  MEM_LAT  4   cycles from mem_en (read) to matching mem_rvalid; memory returns reads in order
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       asynchronous, active-high reset
//  i_miss       in   1       I-cache fill request; held high until i_fill_done
//  i_miss_addr  in   ADDR_W  I-side miss byte address
//  d_miss       in   1       D-cache fill request; held high until d_fill_done
//  d_miss_addr  in   ADDR_W  D-side miss byte address
//  d_wr_req     in   1       write-through store request; held until d_wr_done
//  d_wr_addr    in   ADDR_W  store byte address
//  d_wr_data    in   DATA_W  store data
//  mem_en       out  1       memory request strobe, one access per cycle
//  mem_wr       out  1       1 = write, 0 = read (valid with mem_en)
//  mem_addr     out  ADDR_W  memory byte address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  read-return data
//  mem_rvalid   in   1       read-return valid
//  fill_we      out  1       write one returned word into the selected cache data array
//  fill_to_i    out  1       1 = fill targets I-cache, 0 = D-cache (valid with fill_we)
//  fill_word    out  3       word offset within block for fill_we
//  fill_wdata   out  DATA_W  fill data (= mem_rdata)
//  fill_tag_we  out  1       write tag/valid of the filled block (with last fill_we)
//  i_fill_done  out  1       1-cycle pulse: I fill complete
//  d_fill_done  out  1       1-cycle pulse: D fill complete
//  d_wr_done    out  1       1-cycle pulse: store accepted by memory
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async): state IDLE, issue/return counters 0, latched addr/data 0, every output 0.
//  - States: IDLE, WRITE, FILL_D, FILL_I. Grant is registered: requests sampled in IDLE, serviced
//    from the next cycle. Fixed priority d_wr_req > d_miss > i_miss; losers wait (no queue).
//  - Grant latches the winning address (and store data); later changes on request inputs ignored.
//  - WRITE (1 cycle): mem_en=1, mem_wr=1, mem_addr/mem_wdata = latched; d_wr_done=1; -> IDLE.
//  - FILL_x: base = addr & ~0xF. Issue cycles 0..7 drive mem_en=1, mem_wr=0,
//    mem_addr = base + 2*issue_cnt (ADDR_W-bit wrap, base 0xFFF0 ends at 0xFFFE).
//    Each mem_rvalid in FILL_x: fill_we=1, fill_word=ret_cnt, fill_wdata=mem_rdata,
//    fill_to_i=(state==FILL_I); ret_cnt++. 8th return: also fill_tag_we=1 and done pulse; -> IDLE.
//  - Fill latency: entered at cycle T, issues T..T+7, returns T+MEM_LAT..T+7+MEM_LAT,
//    done pulse at T+7+MEM_LAT, IDLE at T+8+MEM_LAT (requests sampled there).
//  - Requester drops its request in the cycle after its done pulse; a request still high in IDLE
//    is treated as new.
//  - mem_rvalid in IDLE/WRITE is ignored (no fill_we, no counter change).
//  - Outputs combinational from state/counters; mem_* = 0 when not issuing.
//  - Reset mid-fill: abort immediately, no done pulse, no fill_tag_we; memory shares rst, so no
//    stale returns arrive.
// TESTING
//  1. i_miss=1, addr 0x1234 at cyc0 -> reads 0x1230..0x123E cyc1-8; fill_we fill_to_i=1
//     words 0..7 cyc5-12; fill_tag_we+i_fill_done cyc12; busy low cyc13.
//  2. d_miss 0x0040 + i_miss 0x2000 both at cyc0 -> D fill first (d_fill_done cyc12),
//     I fill issues 0x2000.. from cyc14, i_fill_done cyc25.
//  3. d_wr_req (0x0100,0xBEEF) + d_miss + i_miss at cyc0 -> cyc1 mem_wr=1 addr 0x0100 data 0xBEEF
//     d_wr_done=1; D fill issues from cyc3, then I fill.
//  4. i_miss 0xFFFF -> addresses 0xFFF0..0xFFFE, no carry beyond 16 bits.
//  5. Assert rst at cyc7 of fill -> all outputs 0 same cycle; no done; after release, held
//     i_miss restarts full 8-word fill.
//  6. mem_rvalid=1, mem_rdata=0xDEAD while IDLE -> fill_we, fill_tag_we stay 0.

Source files
------------

// File: rtl/mem_fill_arbiter.sv
// Arbitrates the shared pipelined main-memory port between write-through stores, D-cache fills
// and I-cache fills, sequencing 8-word block fills and steering returned words into the caches.
module mem_fill_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              fill_we,
    output logic              fill_to_i,
    output logic [2:0]        fill_word,
    output logic [DATA_W-1:0] fill_wdata,
    output logic              fill_tag_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WRITE, FILL_D, FILL_I} state_t;

    state_t            state, state_nxt;
    logic [3:0]        issue_cnt;
    logic [2:0]        ret_cnt;
    logic [7:0]        fill_cyc;
    logic [ADDR_W-1:0] addr_lat;
    logic [DATA_W-1:0] wdata_lat;
    logic [ADDR_W-1:0] base;
    logic              in_fill, issuing, accept_ret, last_ret;

    assign in_fill    = (state == FILL_D) || (state == FILL_I);
    assign issuing    = in_fill && !issue_cnt[3];
    // A return can only be genuine once the first read has had time to come back.
    assign accept_ret = in_fill && mem_rvalid && (fill_cyc >= 8'(MEM_LAT));
    assign last_ret   = accept_ret && (ret_cnt == 3'd7);
    assign base       = {addr_lat[ADDR_W-1:4], 4'h0};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant latching and fill issue/return bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt <= 4'd0;
            ret_cnt   <= 3'd0;
            fill_cyc  <= 8'd0;
            addr_lat  <= '0;
            wdata_lat <= '0;
        end else if (state == IDLE) begin
            issue_cnt <= 4'd0;
            ret_cnt   <= 3'd0;
            fill_cyc  <= 8'd0;
            if (d_wr_req) begin
                addr_lat  <= d_wr_addr;
                wdata_lat <= d_wr_data;
            end else if (d_miss) begin
                addr_lat <= d_miss_addr;
            end else if (i_miss) begin
                addr_lat <= i_miss_addr;
            end
        end else begin
            if (issuing) begin
                issue_cnt <= issue_cnt + 4'd1;
            end
            if (accept_ret) begin
                ret_cnt <= ret_cnt + 3'd1;
            end
            if (fill_cyc != 8'hFF) begin
                fill_cyc <= fill_cyc + 8'd1;
            end
        end
    end

    // Next-state: fixed priority store > D fill > I fill, sampled only in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_wr_req) begin
                    state_nxt = WRITE;
                end else if (d_miss) begin
                    state_nxt = FILL_D;
                end else if (i_miss) begin
                    state_nxt = FILL_I;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WRITE: state_nxt = IDLE;
            FILL_D, FILL_I: begin
                if (last_ret) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = state;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-port and cache-fill outputs decoded from state and counters
    always_comb begin
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_we     = 1'b0;
        fill_to_i   = 1'b0;
        fill_word   = 3'd0;
        fill_wdata  = '0;
        fill_tag_we = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;
        busy        = (state != IDLE);
        if (state == WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_lat;
            mem_wdata = wdata_lat;
            d_wr_done = 1'b1;
        end else begin
            mem_wr = 1'b0;
        end
        if (issuing) begin
            mem_en   = 1'b1;
            mem_addr = base + ADDR_W'({issue_cnt[2:0], 1'b0});
        end else begin
            fill_word = 3'd0;
        end
        if (accept_ret) begin
            fill_we     = 1'b1;
            fill_to_i   = (state == FILL_I);
            fill_word   = ret_cnt;
            fill_wdata  = mem_rdata;
            fill_tag_we = last_ret;
            i_fill_done = last_ret && (state == FILL_I);
            d_fill_done = last_ret && (state == FILL_D);
        end else begin
            fill_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Randomized and directed bench for mem_fill_arbiter, checked every cycle against a
// transaction-schedule model of grants, fill timing and a latency-4 in-order memory.
`timescale 1ns/1ps
module tb_mem_fill_arbiter;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr_req;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, mem_rvalid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_wdata;
    logic        fill_we, fill_to_i, fill_tag_we, i_fill_done, d_fill_done, d_wr_done, busy;
    logic [2:0]  fill_word;

    typedef struct packed {
        logic        mem_en;
        logic        mem_wr;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic        fill_we;
        logic        fill_to_i;
        logic [2:0]  fill_word;
        logic [15:0] fill_wdata;
        logic        tag_we;
        logic        i_done;
        logic        d_done;
        logic        w_done;
        logic        busy;
    } outs_t;

    outs_t obs, exp_o;
    int    total = 0, bad = 0, cyc = 0;
    logic [15:0] key;
    bit    rand_mode = 1'b0;
    logic  force_rv = 1'b0;
    logic [15:0] force_rd = 16'h0000;

    // model job: 0 none, 1 store, 2 D fill, 3 I fill; starts at cycle job_t
    logic [1:0]  job_kind;
    int          job_t, mk;
    logic [15:0] job_addr, job_data, mbase;

    logic        pv[4];
    logic [15:0] pa[4];

    always #5 clk = ~clk;

    mem_fill_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .d_wr_req(d_wr_req), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .fill_we(fill_we), .fill_to_i(fill_to_i), .fill_word(fill_word), .fill_wdata(fill_wdata),
        .fill_tag_we(fill_tag_we), .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .d_wr_done(d_wr_done), .busy(busy)
    );

    assign obs = {mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_to_i, fill_word, fill_wdata,
                  fill_tag_we, i_fill_done, d_fill_done, d_wr_done, busy};

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return (a * 16'd40503) ^ key;
    endfunction

    // Memory: reads return in order LAT cycles after issue; reset clears in-flight reads
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 16'h0000;
            end
        end else begin
            pv[0] <= mem_en && !mem_wr;
            pa[0] <= mem_addr;
            for (int i = 1; i < 4; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
        end
    end

    assign mem_rvalid = pv[3] | force_rv;
    assign mem_rdata  = pv[3] ? mem_val(pa[3]) : (force_rv ? force_rd : 16'h0000);

    always @(posedge clk) cyc <= cyc + 1;

    // Reference schedule: grant from idle with fixed priority, job lasts 1 or LAT+8 cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            job_kind <= 2'd0;
        end else if (job_kind == 2'd0) begin
            job_t <= cyc + 1;
            if (d_wr_req) begin
                job_kind <= 2'd1; job_addr <= d_wr_addr; job_data <= d_wr_data;
            end else if (d_miss) begin
                job_kind <= 2'd2; job_addr <= d_miss_addr;
            end else if (i_miss) begin
                job_kind <= 2'd3; job_addr <= i_miss_addr;
            end
        end else if ((job_kind == 2'd1 && cyc == job_t) || (job_kind != 2'd1 && cyc == job_t + LAT + 7)) begin
            job_kind <= 2'd0;
        end
    end

    always_comb begin
        exp_o = '0;
        mk    = cyc - job_t;
        mbase = {job_addr[15:4], 4'h0};
        if (!rst && job_kind != 2'd0) begin
            exp_o.busy = 1'b1;
            if (job_kind == 2'd1) begin
                exp_o.mem_en = 1'b1; exp_o.mem_wr = 1'b1;
                exp_o.mem_addr = job_addr; exp_o.mem_wdata = job_data; exp_o.w_done = 1'b1;
            end else begin
                if (mk >= 0 && mk < 8) begin
                    exp_o.mem_en   = 1'b1;
                    exp_o.mem_addr = mbase + 16'(2 * mk);
                end
                if (mk >= LAT && mk < LAT + 8) begin
                    exp_o.fill_we    = 1'b1;
                    exp_o.fill_to_i  = (job_kind == 2'd3);
                    exp_o.fill_word  = 3'(mk - LAT);
                    exp_o.fill_wdata = mem_val(mbase + 16'(2 * (mk - LAT)));
                end
                if (mk == LAT + 7) begin
                    exp_o.tag_we = 1'b1;
                    exp_o.i_done = (job_kind == 2'd3);
                    exp_o.d_done = (job_kind == 2'd2);
                end
            end
        end
    end

    // Advance one cycle; requesters drop the cycle after their done pulse
    task automatic tick();
        logic di, dd, dw;
        di = exp_o.i_done; dd = exp_o.d_done; dw = exp_o.w_done;
        @(posedge clk); #1;
        if (di) i_miss = 1'b0;
        if (dd) d_miss = 1'b0;
        if (dw) d_wr_req = 1'b0;
        if (rand_mode) begin
            if (!i_miss && !di && $urandom_range(3) == 0) begin
                i_miss = 1'b1; i_miss_addr = 16'($urandom);
            end
            if (!d_miss && !dd && $urandom_range(3) == 0) begin
                d_miss = 1'b1; d_miss_addr = 16'($urandom);
            end
            if (!d_wr_req && !dw && $urandom_range(5) == 0) begin
                d_wr_req = 1'b1; d_wr_addr = 16'($urandom); d_wr_data = 16'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0; d_wr_req = 1'b0;
        i_miss_addr = 16'h0000; d_miss_addr = 16'h0000; d_wr_addr = 16'h0000; d_wr_data = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (obs !== 60'h0) begin
            bad++; $display("FAIL reset: got %h want 0", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_i_fill();
        int done_at = -1, nwe = 0;
        i_miss = 1'b1; i_miss_addr = 16'h1234;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_o) begin
                bad++; $display("FAIL i_fill cyc%0d: got %h want %h", k, obs, exp_o);
            end
            if (i_fill_done) done_at = k;
            if (fill_we) nwe++;
            tick();
        end
        total++;
        if (done_at != 12 || nwe != 8) begin
            bad++; $display("FAIL i_fill_timing: done at %0d with %0d words, want 12 and 8", done_at, nwe);
        end
    endtask

    task automatic test_priority();
        int d_at = -1, i_at = -1;
        d_miss = 1'b1; d_miss_addr = 16'h0040; i_miss = 1'b1; i_miss_addr = 16'h2000;
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_o) begin
                bad++; $display("FAIL priority cyc%0d: got %h want %h", k, obs, exp_o);
            end
            if (d_fill_done) d_at = k;
            if (i_fill_done) i_at = k;
            tick();
        end
        total++;
        if (d_at != 12 || i_at != 25) begin
            bad++; $display("FAIL priority_timing: d done %0d i done %0d, want 12 and 25", d_at, i_at);
        end
    endtask

    task automatic test_write();
        int w_at = -1, rd_at = -1;
        d_wr_req = 1'b1; d_wr_addr = 16'h0100; d_wr_data = 16'hBEEF;
        d_miss = 1'b1; d_miss_addr = 16'h0300; i_miss = 1'b1; i_miss_addr = 16'h0500;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_o) begin
                bad++; $display("FAIL write cyc%0d: got %h want %h", k, obs, exp_o);
            end
            if (d_wr_done && mem_wr && mem_addr == 16'h0100 && mem_wdata == 16'hBEEF) w_at = k;
            if (mem_en && !mem_wr && rd_at < 0) rd_at = k;
            tick();
        end
        total++;
        if (w_at != 1 || rd_at != 3) begin
            bad++; $display("FAIL write_timing: store at %0d first read at %0d, want 1 and 3", w_at, rd_at);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] last_a = 16'h0000;
        i_miss = 1'b1; i_miss_addr = 16'hFFFF;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_o) begin
                bad++; $display("FAIL wrap cyc%0d: got %h want %h", k, obs, exp_o);
            end
            if (mem_en) last_a = mem_addr;
            tick();
        end
        total++;
        if (last_a !== 16'hFFFE) begin
            bad++; $display("FAIL wrap_last: got %h want fffe", last_a);
        end
    endtask

    task automatic test_reset_mid_fill();
        int nwe = 0, ndone = 0;
        i_miss = 1'b1; i_miss_addr = 16'($urandom);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_o) begin
                bad++; $display("FAIL rst_mid pre cyc%0d: got %h want %h", k, obs, exp_o);
            end
            tick();
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 60'h0) begin
            bad++; $display("FAIL rst_mid_outputs: got %h want 0", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_o) begin
                bad++; $display("FAIL rst_mid post cyc%0d: got %h want %h", k, obs, exp_o);
            end
            if (fill_we) nwe++;
            if (i_fill_done) ndone++;
            tick();
        end
        total++;
        if (nwe != 8 || ndone != 1) begin
            bad++; $display("FAIL rst_mid_refill: %0d words %0d dones, want 8 and 1", nwe, ndone);
        end
    endtask

    task automatic test_idle_rvalid();
        force_rv = 1'b1; force_rd = 16'hDEAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (fill_we !== 1'b0 || fill_tag_we !== 1'b0 || obs !== exp_o) begin
                bad++; $display("FAIL idle_rvalid cyc%0d: got %h want %h", k, obs, exp_o);
            end
            tick();
        end
        force_rv = 1'b0;
    endtask

    task automatic test_random();
        rand_mode = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            total++;
            if (obs !== exp_o) begin
                bad++; $display("FAIL random cyc%0d: got %h want %h", k, obs, exp_o);
            end
            if (k == 1000) rand_mode = 1'b0;
            tick();
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        key = 16'($urandom);
        rst = 1'b1;
        test_reset();
        test_i_fill();
        test_priority();
        test_write();
        test_wrap();
        test_reset_mid_fill();
        test_idle_rvalid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
